apb_periph_xbar: RTL and testbench

- Parametrised, registered APB decoder/bridge. Successor to the fixed three-peripheral bus wrapper.
- Fans one upstream APB slave port out to NB_SLAVE downstream APB master ports, using a runtime address map.
- Adds registered decode (timing break), decode-miss error response, per-transfer timeout with abort, and an error counter.
- Sits between the core's APB bridge and the peripherals (GPIO, UART, timer, and later ones).

---
 rtl/apb_periph_xbar.sv | 202 ++++++++++++++++++++
 tb/tb_apb_periph_xbar.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_periph_xbar.sv
// apb_periph_xbar: registered APB decoder/bridge. One upstream APB slave port
// fans out to NB_SLAVE downstream APB master ports through a runtime address
// map. Adds a decode-miss error, a per-transfer timeout with abort, and a
// saturating error counter.
module apb_periph_xbar #(
    parameter int NB_SLAVE       = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERRCNT_W       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [ADDR_W-1:0]            paddr_i,
    input  logic [DATA_W-1:0]            pwdata_i,
    input  logic [DATA_W/8-1:0]          pstrb_i,
    output logic [DATA_W-1:0]            prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    input  logic [NB_SLAVE*ADDR_W-1:0]   start_addr_i,
    input  logic [NB_SLAVE*ADDR_W-1:0]   end_addr_i,
    output logic [NB_SLAVE-1:0]          m_psel_o,
    output logic                         m_penable_o,
    output logic                         m_pwrite_o,
    output logic [ADDR_W-1:0]            m_paddr_o,
    output logic [DATA_W-1:0]            m_pwdata_o,
    output logic [DATA_W/8-1:0]          m_pstrb_o,
    input  logic [NB_SLAVE*DATA_W-1:0]   m_prdata_i,
    input  logic [NB_SLAVE-1:0]          m_pready_i,
    input  logic [NB_SLAVE-1:0]          m_pslverr_i,
    output logic                         timeout_o,
    output logic [ERRCNT_W-1:0]          err_cnt_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
    // The timeout counter only needs to hold 0 .. TIMEOUT_CYCLES-1.
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t              state_reg;
    logic [NB_SLAVE-1:0] m_psel_reg;
    logic                m_penable_reg;
    logic                m_pwrite_reg;
    logic [ADDR_W-1:0]   m_paddr_reg;
    logic [DATA_W-1:0]   m_pwdata_reg;
    logic [STRB_W-1:0]   m_pstrb_reg;
    logic [DATA_W-1:0]   prdata_reg;
    logic                pready_reg;
    logic                pslverr_reg;
    logic                timeout_reg;
    logic [ERRCNT_W-1:0] err_cnt_reg;
    logic [TO_W-1:0]     to_cnt_reg;

    logic [NB_SLAVE-1:0] hit;
    logic [NB_SLAVE-1:0] dec_onehot;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_any;
    logic [DATA_W-1:0]   rd_masked [NB_SLAVE];
    logic [DATA_W-1:0]   slv_rdata;
    logic                slv_ready;
    logic                slv_err;
    logic [ERRCNT_W-1:0] err_cnt_inc;

    // Per-slave range compare and one-hot select for the winning index; the
    // read-data slices are masked by the latched select so only the active
    // slave contributes to the return path.
    genvar gi;
    generate
        for (gi = 0; gi < NB_SLAVE; gi++) begin : g_slave
            assign hit[gi] = (paddr_i >= start_addr_i[gi*ADDR_W +: ADDR_W]) &&
                             (paddr_i <= end_addr_i[gi*ADDR_W +: ADDR_W]);
            assign dec_onehot[gi] = dec_any && (dec_idx == IDX_W'(gi));
            assign rd_masked[gi]  = m_prdata_i[gi*DATA_W +: DATA_W] & {DATA_W{m_psel_reg[gi]}};
        end
    endgenerate

    // Priority encode the hit vector: the lowest hitting index wins on overlap.
    always_comb begin
        dec_idx = '0;
        dec_any = 1'b0;
        for (int i = NB_SLAVE - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_idx = IDX_W'(i);
                dec_any = 1'b1;
            end
        end
    end

    // Collapse the masked read-data slices into the active slave's data.
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            slv_rdata = slv_rdata | rd_masked[i];
        end
    end

    assign slv_ready   = |(m_pready_i & m_psel_reg);
    assign slv_err     = |(m_pslverr_i & m_psel_reg);
    assign err_cnt_inc = (err_cnt_reg == '1) ? err_cnt_reg : err_cnt_reg + 1'b1;

    // Transfer FSM with all outputs registered; response flags are one-cycle
    // pulses cleared by default every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            m_psel_reg    <= '0;
            m_penable_reg <= 1'b0;
            m_pwrite_reg  <= 1'b0;
            m_paddr_reg   <= '0;
            m_pwdata_reg  <= '0;
            m_pstrb_reg   <= '0;
            prdata_reg    <= '0;
            pready_reg    <= 1'b0;
            pslverr_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            err_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
        end else begin
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (psel_i && penable_i) begin
                        m_pwrite_reg <= pwrite_i;
                        m_paddr_reg  <= paddr_i;
                        m_pwdata_reg <= pwdata_i;
                        m_pstrb_reg  <= pstrb_i;
                        if (dec_any) begin
                            m_psel_reg <= dec_onehot;
                            state_reg  <= ST_SETUP;
                        end else begin
                            pready_reg  <= 1'b1;
                            pslverr_reg <= 1'b1;
                            err_cnt_reg <= err_cnt_inc;
                            state_reg   <= ST_ERR;
                        end
                    end
                end
                ST_SETUP: begin
                    m_penable_reg <= 1'b1;
                    to_cnt_reg    <= '0;
                    state_reg     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Ready wins over a timeout landing in the same cycle.
                    if (slv_ready) begin
                        pready_reg    <= 1'b1;
                        pslverr_reg   <= slv_err;
                        prdata_reg    <= m_pwrite_reg ? '0 : slv_rdata;
                        m_psel_reg    <= '0;
                        m_penable_reg <= 1'b0;
                        if (slv_err) begin
                            err_cnt_reg <= err_cnt_inc;
                        end
                        state_reg <= ST_RESP;
                    end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
                        pready_reg    <= 1'b1;
                        pslverr_reg   <= 1'b1;
                        timeout_reg   <= 1'b1;
                        m_psel_reg    <= '0;
                        m_penable_reg <= 1'b0;
                        err_cnt_reg   <= err_cnt_inc;
                        state_reg     <= ST_ERR;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                ST_ERR:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign m_psel_o    = m_psel_reg;
    assign m_penable_o = m_penable_reg;
    assign m_pwrite_o  = m_pwrite_reg;
    assign m_paddr_o   = m_paddr_reg;
    assign m_pwdata_o  = m_pwdata_reg;
    assign m_pstrb_o   = m_pstrb_reg;
    assign prdata_o    = prdata_reg;
    assign pready_o    = pready_reg;
    assign pslverr_o   = pslverr_reg;
    assign timeout_o   = timeout_reg;
    assign err_cnt_o   = err_cnt_reg;

endmodule

// File: tb/tb_apb_periph_xbar.sv
// Testbench for apb_periph_xbar: table of upstream transfers with per-slave
// response models, a response scoreboard, plus hand-written overlap and
// mid-transfer reset sequences.
module tb_apb_periph_xbar;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [3:0]      pstrb;
    logic [DW-1:0]   prdata_o;
    logic            pready_o, pslverr_o;
    logic [NS*AW-1:0] start_addr, end_addr;
    logic [NS-1:0]   m_psel_o;
    logic            m_penable_o, m_pwrite_o;
    logic [AW-1:0]   m_paddr_o;
    logic [DW-1:0]   m_pwdata_o;
    logic [3:0]      m_pstrb_o;
    logic [NS*DW-1:0] m_prdata;
    logic [NS-1:0]   m_pready, m_pslverr;
    logic            timeout_o;
    logic [15:0]     err_cnt_o;

    logic [AW-1:0]   map_start [NS];
    logic [AW-1:0]   map_end   [NS];
    logic [DW-1:0]   slv_rd    [NS];
    logic [NS-1:0]   slv_err;
    int              slv_wait;
    int              acc_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_err_cnt = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;
    resp_t exp_q[$];

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            wait_c;
        logic [DW-1:0] rdata;
        logic          serr;
        logic [NS-1:0] exp_sel;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
        logic          exp_to;
    } vec_t;

    apb_periph_xbar #(
        .NB_SLAVE(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERRCNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pstrb_o(m_pstrb_o),
        .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    assign start_addr = {map_start[2], map_start[1], map_start[0]};
    assign end_addr   = {map_end[2], map_end[1], map_end[0]};
    assign m_prdata   = {slv_rd[2], slv_rd[1], slv_rd[0]};
    assign m_pslverr  = slv_err;
    // Only the selected slave answers, after slv_wait not-ready ACCESS cycles.
    assign m_pready   = m_psel_o & {NS{m_penable_o && (acc_cnt == slv_wait)}};

    // Slave model: counts ACCESS cycles of the current downstream transfer.
    always @(posedge clk) begin
        if (m_penable_o && (m_psel_o != '0)) acc_cnt <= acc_cnt + 1;
        else                                 acc_cnt <= 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             pass_cnt++;
    endtask

    // Scoreboard: every upstream response is matched against the queued expectation.
    always @(negedge clk) begin : mon
        resp_t e;
        if (pready_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pready", 64'(pready_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("prdata", 64'(prdata_o), 64'(e.rdata));
                chk("pslverr", 64'(pslverr_o), 64'(e.err));
            end
        end
    end

    task automatic run_vec(input vec_t v, input int id);
        int lat = 0, sel_cyc = 0, to_pulses = 0, exp_sel_cyc;
        bit got = 0, bad_sel = 0, bad_shared = 0;
        exp_q.push_back('{v.exp_rdata, v.exp_err});
        for (int k = 0; k < NS; k++) begin
            slv_rd[k]  = v.exp_sel[k] ? v.rdata : (~v.rdata ^ DW'(k));
            slv_err[k] = v.exp_sel[k] ? v.serr : ~v.serr;
        end
        slv_wait = v.wait_c;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = v.wr;
        paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (m_psel_o != '0) begin
                sel_cyc++;
                if (m_psel_o != v.exp_sel) bad_sel = 1;
                if (m_pwrite_o != v.wr || m_paddr_o != v.addr ||
                    m_pwdata_o != v.wdata || m_pstrb_o != v.strb) bad_shared = 1;
            end
            if (timeout_o) to_pulses++;
            if (pready_o) got = 1;
        end
        exp_sel_cyc = v.exp_to ? (TO + 1) : ((v.exp_sel != '0) ? v.wait_c + 2 : 0);
        if (v.exp_err) exp_err_cnt++;
        chk("pready_seen", 64'(got), 64'd1);
        if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("psel_cycles", 64'(sel_cyc), 64'(exp_sel_cyc));
        chk("psel_target", 64'(bad_sel), 64'd0);
        chk("shared_out", 64'(bad_shared), 64'd0);
        chk("timeout_pulses", 64'(to_pulses), 64'(v.exp_to));
        chk("err_cnt", 64'(err_cnt_o), 64'(exp_err_cnt));
        $display("xfer %0d: %s addr=0x%08h lat=%0d prdata=0x%08h pslverr=%0b err_cnt=%0d",
                 id, v.wr ? "WR" : "RD", v.addr, lat, prdata_o, pslverr_o, err_cnt_o);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic default_map();
        map_start[0] = 32'h1A10_0000; map_end[0] = 32'h1A10_0FFF;
        map_start[1] = 32'h1A10_1000; map_end[1] = 32'h1A10_1FFF;
        map_start[2] = 32'h1A10_2000; map_end[2] = 32'h1A10_2FFF;
    endtask

    vec_t vecs[11];
    vec_t hv;

    initial begin
        //          wr    addr          wdata         strb     wait rdata         serr  sel     exp_rdata     err  lat to
        vecs[0]  = '{1'b0, 32'h1A101004, 32'h0,        4'b0000, 0, 32'hDEADBEEF, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0, 3, 1'b0};
        vecs[1]  = '{1'b1, 32'h1A102010, 32'h55AA,     4'b0011, 4, 32'h12345678, 1'b0, 3'b100, 32'h0,        1'b0, 7, 1'b0};
        vecs[2]  = '{1'b0, 32'h20000000, 32'h0,        4'b0000, 0, 32'h11111111, 1'b0, 3'b000, 32'h0,        1'b1, 1, 1'b0};
        vecs[3]  = '{1'b0, 32'h1A100000, 32'h0,        4'b1111, 1, 32'hCAFEF00D, 1'b1, 3'b001, 32'hCAFEF00D, 1'b1, 4, 1'b0};
        vecs[4]  = '{1'b1, 32'h1A100FFF, 32'hA5A5A5A5, 4'b1111, 0, 32'h0F0F0F0F, 1'b0, 3'b001, 32'h0,        1'b0, 3, 1'b0};
        vecs[5]  = '{1'b0, 32'h1A102FFF, 32'h0,        4'b0000, 2, 32'h0BADC0DE, 1'b0, 3'b100, 32'h0BADC0DE, 1'b0, 5, 1'b0};
        vecs[6]  = '{1'b0, 32'h1A103000, 32'h0,        4'b0000, 0, 32'h22222222, 1'b0, 3'b000, 32'h0,        1'b1, 1, 1'b0};
        vecs[7]  = '{1'b1, 32'h1A0FFFFF, 32'h77,       4'b0001, 0, 32'h33333333, 1'b0, 3'b000, 32'h0,        1'b1, 1, 1'b0};
        vecs[8]  = '{1'b0, 32'h1A101000, 32'h0,        4'b0000, 7, 32'h13579BDF, 1'b0, 3'b010, 32'h13579BDF, 1'b0, 10, 1'b0};
        vecs[9]  = '{1'b0, 32'h1A100040, 32'h0,        4'b0000, 8, 32'h44444444, 1'b0, 3'b001, 32'h0,        1'b1, 10, 1'b1};
        vecs[10] = '{1'b1, 32'h1A102004, 32'h9ABC,     4'b1000, 0, 32'h66666666, 1'b1, 3'b100, 32'h0,        1'b1, 3, 1'b0};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; slv_wait = 0; slv_err = '0;
        for (int k = 0; k < NS; k++) slv_rd[k] = '0;
        default_map();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({m_psel_o, m_penable_o, m_pwrite_o, pready_o, pslverr_o, timeout_o}), 64'd0);
        chk("reset_prdata", 64'(prdata_o), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("reset_shared", 64'({m_paddr_o, m_pstrb_o}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Overlapping map: slave1 base moved into slave0's range; slave0 must win.
        map_start[1] = 32'h1A10_0800;
        hv = '{1'b0, 32'h1A100900, 32'h0, 4'b0000, 0, 32'h600DF00D, 1'b1, 3'b001, 32'h600DF00D, 1'b1, 3, 1'b0};
        run_vec(hv, 11);
        default_map();

        // Reset during a slave1 ACCESS cycle: transfer dropped, no response.
        slv_wait = 20;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1A101008;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_access", 64'({m_psel_o, m_penable_o}), 64'({3'b010, 1'b1}));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_drop_psel", 64'({m_psel_o, m_penable_o}), 64'd0);
        chk("reset_drop_pready", 64'(pready_o), 64'd0);
        chk("reset_clear_err_cnt", 64'(err_cnt_o), 64'd0);
        $display("xfer reset: m_psel=%b pready=%0b err_cnt=%0d", m_psel_o, pready_o, err_cnt_o);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        exp_err_cnt = 0;
        repeat (2) @(posedge clk);
        run_vec(vecs[0], 12);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
